multi_alarm_clock: RTL and testbench
====================================

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1000, clk cycles per second (>=2).
REQ-002 SHALL have parameter N_ALARMS, default 4, independent alarm channels (1..8).
REQ-003 SHALL have parameter RING_SECS, default 60, max ring duration in seconds.
REQ-004 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- global_reset  in  1  asynchronous, active-high reset
- mode  in  2  CLOCK=0, CLOCK_EDIT=1, ALARM_EDIT=2, TIMER=3
- select  in  2  NONE=0, SEC=1, MIN=2, HOUR=3
- increment  in  1  one-cycle edit pulse
- alarm_idx  in  clog2(N_ALARMS) (min 1)  channel shown/edited in ALARM_EDIT
- alarm_enable  in  N_ALARMS  per-channel arm
- start_stop  in  1  timer run toggle pulse
- snooze  in  1  pulse
- ring_ack  in  1  pulse
- sec_out  out  6;  min_out  out  6;  hour_out  out  5  displayed time
- ring_vec  out  N_ALARMS  per-channel ringing
- alarm_out  out  1  OR of ring_vec
- timer_done  out  1  sticky countdown expiry

Function
REQ-006 SHALL generate a one-cycle tick every TICKS_PER_SEC clk cycles from a free-running prescaler.
REQ-007 SHALL advance clock time on tick: sec 0..59, carry to min 0..59, carry to hour 0..23; 23:59:59 wraps to 00:00:00.
REQ-008 In CLOCK_EDIT with select!=NONE, clock time SHALL hold; increment adds 1 to the selected field modulo its range, no carry; select=SEC increment also clears the prescaler.
REQ-009 In ALARM_EDIT, increment SHALL edit the selected field of channel alarm_idx (hour/min only; SEC ignored, alarm seconds fixed 0); out-of-range alarm_idx ignored.
REQ-010 Each channel SHALL have states IDLE, RINGING, SNOOZED.
REQ-011 IDLE->RINGING on the tick at which new clock time equals hh:mm:00 of the channel and alarm_enable[i]=1.
REQ-012 RINGING->IDLE on ring_ack, on alarm_enable[i]=0, or after RING_SECS ticks.
REQ-013 RINGING->SNOOZED on snooze; SNOOZED->RINGING after SNOOZE_MIN*60 ticks; SNOOZED->IDLE on ring_ack or alarm_enable[i]=0.
REQ-014 snooze and ring_ack SHALL act on all channels in the relevant state; same-cycle snooze+ring_ack: ring_ack wins.
REQ-015 Match and snooze expiry in same tick: channel enters RINGING, ring counter restarts.
REQ-016 TIMER: while stopped, increment edits selected field of countdown value; start_stop toggles run only when value nonzero; running, each tick decrements hh:mm:ss with borrow.
REQ-017 Countdown reaching 00:00:00 SHALL stop the timer and set timer_done; cleared by ring_ack or start_stop; start_stop at zero only clears timer_done.
REQ-018 Display mux (combinational from registered state): CLOCK/CLOCK_EDIT clock time, ALARM_EDIT channel alarm_idx with sec_out=0, TIMER countdown value.
REQ-019 Clock, alarms and timer SHALL keep running regardless of mode.

Reset
REQ-020 global_reset SHALL asynchronously clear prescaler, clock, all alarm times, countdown, ring/snooze counters; channels to IDLE; timer stopped; all outputs 0.
REQ-021 Reset mid-ring or mid-countdown SHALL abort with no residual ring_vec or timer_done after release.

Configuration
REQ-022 With MULTI_ALARM_SNOOZE_EN defined, snooze and SNOOZED behave per REQ-013/015; without it, snooze is ignored, SNOOZED and its counter are absent.

Structure
REQ-023 Package multi_alarm_clock_pkg SHALL hold mode, select and channel-state encodings and field limits (59, 23).
REQ-024 Per-channel state machine, alarm time and ring/snooze counters SHALL be sub-module alarm_channel, instantiated N_ALARMS times.

Verification (TICKS_PER_SEC=4, N_ALARMS=2, RING_SECS=3, SNOOZE_MIN=1)
REQ-025 Set clock 23:59:58, run 8 cycles -> 00:00:00, no carry leak.
REQ-026 Alarm0 06:30, enabled, clock 06:29:59 -> ring_vec=01 at next tick, 00 after 3 further ticks.
REQ-027 Ringing, snooze -> ring_vec=00, re-ring after 60 ticks; with macro undefined, ring stays until timeout.
REQ-028 Both channels ringing, snooze+ring_ack same cycle -> both IDLE, no re-ring.
REQ-029 Timer 00:00:02, start_stop -> timer_done=1 after 2 ticks, count held at 0; start_stop -> timer_done=0.
REQ-030 global_reset asserted mid-ring, asynchronously off clk edge -> all outputs 0 immediately, hold 0 after release.

Source files
------------

// File: rtl/multi_alarm_clock_pkg.sv
`default_nettype none
// ============================================================================
// multi_alarm_clock_pkg : mode/select/channel encodings, field limits, helpers
// Rev 1.0
// ============================================================================
package multi_alarm_clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK      = 2'd0,
    MODE_CLOCK_EDIT = 2'd1,
    MODE_ALARM_EDIT = 2'd2,
    MODE_TIMER      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SEC  = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_HOUR = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RINGING = 2'd1,
    CH_SNOOZED = 2'd2
  } chan_state_e;

  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;

  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_alarm_clock_alarm_channel.sv
`default_nettype none
// ============================================================================
// alarm_channel : one alarm time plus IDLE/RINGING/SNOOZED state machine
// Snooze support compiled in with MULTI_ALARM_SNOOZE_EN.  Rev 1.0
// ============================================================================
module alarm_channel
  import multi_alarm_clock_pkg::*;
#(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       advance_i,
  input  logic [4:0] now_hour_i,
  input  logic [5:0] now_min_i,
  input  logic [5:0] now_sec_i,
  input  logic       enable_i,
  input  logic       snooze_i,
  input  logic       ring_ack_i,
  input  logic       inc_min_i,
  input  logic       inc_hour_i,
  output logic [4:0] hour_o,
  output logic [5:0] min_o,
  output logic       ringing_o
);

  localparam int unsigned RING_W = $clog2(RING_SECS + 1);

  chan_state_e       state_q, state_d;
  logic [RING_W-1:0] ring_q, ring_d;
  logic [4:0]        hour_q, hour_d;
  logic [5:0]        min_q, min_d;
  logic              match;

`ifdef MULTI_ALARM_SNOOZE_EN
  localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int unsigned SNZ_W     = $clog2(SNZ_TICKS + 1);
  logic [SNZ_W-1:0] snz_q, snz_d;
`else
  logic unused_snooze;
  assign unused_snooze = snooze_i;
`endif

  // Only a real clock advance can trigger; a tick while the clock is held is not a new time.
  assign match = advance_i && enable_i && (now_hour_i == hour_q) &&
                 (now_min_i == min_q) && (now_sec_i == 6'd0);

  always_comb begin
    hour_d = inc_hour_i ? 5'(inc_wrap({1'b0, hour_q}, {1'b0, MAX_HOUR})) : hour_q;
    min_d  = inc_min_i  ? inc_wrap(min_q, MAX_MIN) : min_q;
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
`ifdef MULTI_ALARM_SNOOZE_EN
    snz_d   = snz_q;
`endif
    case (state_q)
      CH_IDLE: begin
        if (match) begin
          state_d = CH_RINGING;
          ring_d  = '0;
        end
      end
      CH_RINGING: begin
        if (ring_ack_i || !enable_i) begin
          state_d = CH_IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
        end else if (snooze_i) begin
          state_d = CH_SNOOZED;
          snz_d   = '0;
`endif
        end else if (tick_i) begin
          if (32'(ring_q) + 32'd1 >= RING_SECS) state_d = CH_IDLE;
          else                                  ring_d  = ring_q + 1'b1;
        end
      end
`ifdef MULTI_ALARM_SNOOZE_EN
      CH_SNOOZED: begin
        if (ring_ack_i || !enable_i) begin
          state_d = CH_IDLE;
        end else if (tick_i) begin
          if (match || (32'(snz_q) + 32'd1 >= SNZ_TICKS)) begin
            state_d = CH_RINGING;
            ring_d  = '0;
          end else begin
            snz_d = snz_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      ring_q  <= '0;
      hour_q  <= '0;
      min_q   <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_q   <= snz_d;
`endif
    end
  end

  assign hour_o    = hour_q;
  assign min_o     = min_q;
  assign ringing_o = (state_q == CH_RINGING);

endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// multi_alarm_clock : time-of-day clock, N alarm channels, countdown timer
// Snooze support compiled in with MULTI_ALARM_SNOOZE_EN.  Rev 1.0
// ============================================================================
module multi_alarm_clock
  import multi_alarm_clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned N_ALARMS      = 4,
  parameter int unsigned RING_SECS     = 60,
  parameter int unsigned SNOOZE_MIN    = 5
) (
  input  logic                                              clk,
  input  logic                                              global_reset,
  input  logic [1:0]                                        mode,
  input  logic [1:0]                                        select,
  input  logic                                              increment,
  input  logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] alarm_idx,
  input  logic [N_ALARMS-1:0]                               alarm_enable,
  input  logic                                              start_stop,
  input  logic                                              snooze,
  input  logic                                              ring_ack,
  output logic [5:0]                                        sec_out,
  output logic [5:0]                                        min_out,
  output logic [4:0]                                        hour_out,
  output logic [N_ALARMS-1:0]                               ring_vec,
  output logic                                              alarm_out,
  output logic                                              timer_done
);

  localparam int unsigned IDX_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int unsigned PRE_W = $clog2(TICKS_PER_SEC);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       tsec_q, tsec_d, tmin_q, tmin_d;
  logic [4:0]       thour_q, thour_d;
  logic             run_q, run_d, done_q, done_d;
  logic             tick, clk_hold, clk_adv, tmr_zero;
  logic [4:0]       ahour [N_ALARMS];
  logic [5:0]       amin  [N_ALARMS];

  assign tick     = (presc_q == PRE_W'(TICKS_PER_SEC - 1));
  assign clk_hold = (mode == MODE_CLOCK_EDIT) && (select != SEL_NONE);
  assign tmr_zero = ({thour_q, tmin_q, tsec_q} == 17'd0);

  // Editing seconds restarts the current second so the new value is shown for a full second.
  always_comb begin
    presc_d = presc_q + 1'b1;
    if ((clk_hold && (select == SEL_SEC) && increment) || tick) presc_d = '0;
  end

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    clk_adv = 1'b0;
    if (clk_hold) begin
      if (increment) begin
        case (select)
          SEL_SEC:  sec_d  = inc_wrap(sec_q, MAX_SEC);
          SEL_MIN:  min_d  = inc_wrap(min_q, MAX_MIN);
          SEL_HOUR: hour_d = 5'(inc_wrap({1'b0, hour_q}, {1'b0, MAX_HOUR}));
          default:  ;
        endcase
      end
    end else if (tick) begin
      clk_adv = 1'b1;
      sec_d   = inc_wrap(sec_q, MAX_SEC);
      if (sec_q == MAX_SEC) begin
        min_d = inc_wrap(min_q, MAX_MIN);
        if (min_q == MAX_MIN) hour_d = 5'(inc_wrap({1'b0, hour_q}, {1'b0, MAX_HOUR}));
      end
    end
  end

  always_comb begin
    tsec_d  = tsec_q;
    tmin_d  = tmin_q;
    thour_d = thour_q;
    run_d   = run_q;
    done_d  = done_q;
    if (start_stop) begin
      done_d = 1'b0;
      if (run_q)          run_d = 1'b0;
      else if (!tmr_zero) run_d = 1'b1;
    end else begin
      if (ring_ack) done_d = 1'b0;
      if (run_q && tick) begin
        if (tsec_q != 6'd0) begin
          tsec_d = tsec_q - 6'd1;
        end else begin
          tsec_d = MAX_SEC;
          if (tmin_q != 6'd0) begin
            tmin_d = tmin_q - 6'd1;
          end else begin
            tmin_d  = MAX_MIN;
            thour_d = thour_q - 5'd1;
          end
        end
        if ({thour_q, tmin_q, tsec_q} == {5'd0, 6'd0, 6'd1}) begin
          run_d  = 1'b0;
          done_d = 1'b1;
        end
      end else if (!run_q && (mode == MODE_TIMER) && increment) begin
        case (select)
          SEL_SEC:  tsec_d  = inc_wrap(tsec_q, MAX_SEC);
          SEL_MIN:  tmin_d  = inc_wrap(tmin_q, MAX_MIN);
          SEL_HOUR: thour_d = 5'(inc_wrap({1'b0, thour_q}, {1'b0, MAX_HOUR}));
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      tsec_q  <= '0;
      tmin_q  <= '0;
      thour_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      tsec_q  <= tsec_d;
      tmin_q  <= tmin_d;
      thour_q <= thour_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_chan
    logic edit_sel;
    assign edit_sel = (mode == MODE_ALARM_EDIT) && increment && (alarm_idx == IDX_W'(i));

    alarm_channel #(
      .RING_SECS (RING_SECS),
      .SNOOZE_MIN(SNOOZE_MIN)
    ) u_chan (
      .clk       (clk),
      .rst       (global_reset),
      .tick_i    (tick),
      .advance_i (clk_adv),
      .now_hour_i(hour_d),
      .now_min_i (min_d),
      .now_sec_i (sec_d),
      .enable_i  (alarm_enable[i]),
      .snooze_i  (snooze),
      .ring_ack_i(ring_ack),
      .inc_min_i (edit_sel && (select == SEL_MIN)),
      .inc_hour_i(edit_sel && (select == SEL_HOUR)),
      .hour_o    (ahour[i]),
      .min_o     (amin[i]),
      .ringing_o (ring_vec[i])
    );
  end

  always_comb begin
    sec_out  = sec_q;
    min_out  = min_q;
    hour_out = hour_q;
    case (mode)
      MODE_ALARM_EDIT: begin
        sec_out  = 6'd0;
        min_out  = 6'd0;
        hour_out = 5'd0;
        if (32'(alarm_idx) < N_ALARMS) begin
          min_out  = amin[alarm_idx];
          hour_out = ahour[alarm_idx];
        end
      end
      MODE_TIMER: begin
        sec_out  = tsec_q;
        min_out  = tmin_q;
        hour_out = thour_q;
      end
      default: ;
    endcase
  end

  assign alarm_out  = |ring_vec;
  assign timer_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// tb_multi_alarm_clock : scoreboard bench with a seconds-based reference model
// Rev 1.0
// ============================================================================
module tb_multi_alarm_clock;

  localparam int TPS = 4;
  localparam int NA  = 2;
  localparam int RS  = 3;
  localparam int SM  = 1;
  localparam int S_IDLE = 0, S_RING = 1, S_SNZ = 2;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] rv;
    logic       ao;
    logic       td;
  } obs_t;

  logic       clk;
  logic       global_reset;
  logic [1:0] mode, select;
  logic       increment;
  logic [0:0] alarm_idx;
  logic [1:0] alarm_enable;
  logic       start_stop, snooze, ring_ack;
  logic [5:0] sec_out, min_out;
  logic [4:0] hour_out;
  logic [1:0] ring_vec;
  logic       alarm_out, timer_done;

  multi_alarm_clock #(
    .TICKS_PER_SEC(TPS),
    .N_ALARMS     (NA),
    .RING_SECS    (RS),
    .SNOOZE_MIN   (SM)
  ) dut (
    .clk         (clk),
    .global_reset(global_reset),
    .mode        (mode),
    .select      (select),
    .increment   (increment),
    .alarm_idx   (alarm_idx),
    .alarm_enable(alarm_enable),
    .start_stop  (start_stop),
    .snooze      (snooze),
    .ring_ack    (ring_ack),
    .sec_out     (sec_out),
    .min_out     (min_out),
    .hour_out    (hour_out),
    .ring_vec    (ring_vec),
    .alarm_out   (alarm_out),
    .timer_done  (timer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time of day and countdown held as plain second counts.
  int pc, tod, tmr;
  bit run, done;
  int alm_h [NA];
  int alm_m [NA];
  int st [NA];
  int ring_left [NA];
  int snz_left [NA];

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic void model_reset();
    pc = 0; tod = 0; tmr = 0; run = 0; done = 0;
    for (int i = 0; i < NA; i++) begin
      alm_h[i] = 0; alm_m[i] = 0; st[i] = S_IDLE; ring_left[i] = 0; snz_left[i] = 0;
    end
  endfunction

  function automatic int edit_hms(input int t, input logic [1:0] sel);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    case (sel)
      2'd1: s = (s + 1) % 60;
      2'd2: m = (m + 1) % 60;
      2'd3: h = (h + 1) % 24;
      default: ;
    endcase
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic void model_step();
    bit tick, hold, adv, match;
    int ntod;
    tick = (pc == TPS - 1);
    hold = (mode == 2'd1) && (select != 2'd0);
    if ((hold && select == 2'd1 && increment) || tick) pc = 0;
    else pc = pc + 1;
    ntod = tod; adv = 0;
    if (hold) begin
      if (increment) ntod = edit_hms(tod, select);
    end else if (tick) begin
      ntod = (tod + 1) % 86400; adv = 1;
    end
    for (int i = 0; i < NA; i++) begin
      match = adv && alarm_enable[i] && (ntod == (alm_h[i] * 60 + alm_m[i]) * 60);
      case (st[i])
        S_IDLE: if (match) begin st[i] = S_RING; ring_left[i] = RS; end
        S_RING: begin
          if (ring_ack || !alarm_enable[i]) st[i] = S_IDLE;
          else if (SNZ_EN && snooze) begin st[i] = S_SNZ; snz_left[i] = SM * 60; end
          else if (tick) begin
            ring_left[i] = ring_left[i] - 1;
            if (ring_left[i] == 0) st[i] = S_IDLE;
          end
        end
        default: begin
          if (ring_ack || !alarm_enable[i]) st[i] = S_IDLE;
          else if (tick) begin
            snz_left[i] = snz_left[i] - 1;
            if (match || snz_left[i] == 0) begin st[i] = S_RING; ring_left[i] = RS; end
          end
        end
      endcase
    end
    tod = ntod;
    if (mode == 2'd2 && increment) begin
      if (select == 2'd3) alm_h[alarm_idx] = (alm_h[alarm_idx] + 1) % 24;
      else if (select == 2'd2) alm_m[alarm_idx] = (alm_m[alarm_idx] + 1) % 60;
    end
    if (start_stop) begin
      done = 0;
      if (run) run = 0;
      else if (tmr != 0) run = 1;
    end else begin
      if (ring_ack) done = 0;
      if (run && tick) begin
        tmr = tmr - 1;
        if (tmr == 0) begin run = 0; done = 1; end
      end else if (!run && mode == 2'd3 && increment) begin
        tmr = edit_hms(tmr, select);
      end
    end
  endfunction

  function automatic obs_t model_expect();
    obs_t e;
    int t;
    e = '0;
    t = (mode == 2'd3) ? tmr : tod;
    if (mode == 2'd2) begin
      e.h = 5'(alm_h[alarm_idx]);
      e.m = 6'(alm_m[alarm_idx]);
    end else begin
      e.h = 5'(t / 3600);
      e.m = 6'((t / 60) % 60);
      e.s = 6'(t % 60);
    end
    for (int i = 0; i < NA; i++) e.rv[i] = (st[i] == S_RING);
    e.ao = |e.rv;
    e.td = done;
    return e;
  endfunction

  function automatic obs_t sample_dut();
    obs_t a;
    a.h = hour_out; a.m = min_out; a.s = sec_out;
    a.rv = ring_vec; a.ao = alarm_out; a.td = timer_done;
    return a;
  endfunction

  task automatic report(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0d:%0d:%0d ring=%b alarm=%b done=%b, want %0d:%0d:%0d ring=%b alarm=%b done=%b",
               name, $time, got.h, got.m, got.s, got.rv, got.ao, got.td,
               want.h, want.m, want.s, want.rv, want.ao, want.td);
    end
  endtask

  // Monitor: the DUT presents a fresh output set after every active edge.
  obs_t mon_exp;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        report("scoreboard", sample_dut(), mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_expect());
    @(negedge clk);
    increment = 0; start_stop = 0; snooze = 0; ring_ack = 0;
  endtask

  task automatic run_cycles(input int n);
    mode = 2'd0; select = 2'd0;
    repeat (n) step();
  endtask

  task automatic edit_pulses(input logic [1:0] md, input logic [1:0] sl, input int n);
    mode = md; select = sl;
    repeat (n) begin
      increment = 1;
      step();
      step();
    end
  endtask

  task automatic set_clock(input int h, input int m, input int s);
    edit_pulses(2'd1, 2'd3, (h - tod / 3600 + 24) % 24);
    edit_pulses(2'd1, 2'd2, (m - (tod / 60) % 60 + 60) % 60);
    edit_pulses(2'd1, 2'd1, (s - tod % 60 + 60) % 60);
    mode = 2'd0; select = 2'd0;
  endtask

  task automatic set_alarm(input int idx, input int h, input int m);
    alarm_idx = 1'(idx);
    edit_pulses(2'd2, 2'd3, (h - alm_h[idx] + 24) % 24);
    edit_pulses(2'd2, 2'd2, (m - alm_m[idx] + 60) % 60);
    mode = 2'd0; select = 2'd0;
  endtask

  task automatic async_reset();
    #2;
    global_reset = 1;
    #1;
    report("async_reset_immediate", sample_dut(), '0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      exp_q.push_back(model_expect());
    end
    @(negedge clk);
    #1 global_reset = 0;
  endtask

  initial begin
    global_reset = 1; mode = 0; select = 0; increment = 0; alarm_idx = 0;
    alarm_enable = 0; start_stop = 0; snooze = 0; ring_ack = 0;
    model_reset();
    @(negedge clk);
    report("reset_state", sample_dut(), '0);
    @(negedge clk);
    global_reset = 0;

    // Midnight rollover
    set_clock(23, 59, 58);
    run_cycles(8);
    run_cycles(4);

    // Single alarm ring and timeout
    set_alarm(0, 6, 30);
    alarm_enable = 2'b01;
    set_clock(6, 29, 59);
    run_cycles(24);

    // Snooze (re-ring when compiled in, otherwise plain timeout)
    set_clock(6, 29, 59);
    run_cycles(6);
    snooze = 1;
    step();
    run_cycles(4 * 62);

    // Two channels ringing, snooze and ring_ack together
    set_alarm(1, 6, 30);
    alarm_enable = 2'b11;
    set_clock(6, 29, 59);
    run_cycles(6);
    snooze = 1; ring_ack = 1;
    step();
    run_cycles(4 * 65);

    // Countdown timer 00:00:02
    edit_pulses(2'd3, 2'd1, 2);
    mode = 2'd3; select = 2'd0;
    start_stop = 1;
    step();
    repeat (14) step();
    start_stop = 1;
    step();
    repeat (4) step();

    // Randomized traffic around alarm times
    for (int k = 0; k < 8; k++) begin
      int ch, tgt;
      ch  = int'($urandom_range(0, NA - 1));
      tgt = ((alm_h[ch] * 60 + alm_m[ch]) * 60 - 3 + 86400) % 86400;
      alarm_enable = 2'($urandom_range(1, 3));
      set_clock(tgt / 3600, (tgt / 60) % 60, tgt % 60);
      for (int c = 0; c < 250; c++) begin
        mode       = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(0, 3));
        select     = 2'($urandom_range(0, 3));
        alarm_idx  = 1'($urandom_range(0, 1));
        increment  = ($urandom_range(0, 4) == 0);
        start_stop = ($urandom_range(0, 29) == 0);
        snooze     = ($urandom_range(0, 29) == 0);
        ring_ack   = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 49) == 0) alarm_enable = alarm_enable ^ 2'($urandom_range(1, 3));
        step();
      end
    end

    // Asynchronous reset in the middle of a ring and a countdown
    set_alarm(0, 6, 30);
    alarm_enable = 2'b01;
    if (run) begin
      start_stop = 1;
      step();
    end
    edit_pulses(2'd3, 2'd2, 1);
    mode = 2'd3; start_stop = 1;
    step();
    set_clock(6, 29, 59);
    run_cycles(6);
    async_reset();
    run_cycles(40);

    @(posedge clk);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #3000000;
    n_mis++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
